usb_mouse_ps2: RTL and testbench
================================

Name: usb_mouse_ps2

Overview:
- Parametrised successor to the dock USB mouse decoder.
- Converts the APF controller-4 mouse report stream (type 0x5) into rate-limited PS/2-style mouse packets on a 25-bit `ps2_mouse` bus with toggle strobe.
- Detects reports via the 16-bit report counter and accumulates deltas with saturation.
- Drains large movements across multiple packets, so no motion is lost when the host core reads slower than USB reports arrive. Sits between the APF bridge inputs and the core's PS/2 mouse consumer.

Parameters:
- ACC_W, 16, accumulator width in bits (signed); must be >= 10.
- GAP_CYCLES, 1024, minimum clk cycles between consecutive packet toggles; must be >= 1.
- SCALE_SHIFT, 0, arithmetic right shift applied to each report delta before accumulation (0..4).
- INVERT_Y, 1, 1 = negate Y, because USB is down-positive and PS/2 is up-positive.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cont4_key  in  32  [31:28] input type, [15:0] report counter (byte-swapped LE)
- cont4_joy  in  32  [23:16] buttons, [15:0] X delta (byte-swapped LE)
- cont4_trig  in  16  Y delta (byte-swapped LE)
- mouse_active  out  1  synchronized type == 0x5
- mouse_buttons  out  3  synchronized {middle,right,left}
- report_strobe  out  1  one-cycle pulse per accepted report
- ps2_mouse  out  25  [7:0] status, [15:8] X, [23:16] Y, [24] toggle per packet

Behaviour:
- Reset: all outputs, accumulators, gap counter and last-counter registers cleared to 0.
  - reset_n is asserted asynchronously and released synchronously through a 2-flop release synchronizer.
  - Reset mid-packet discards pending motion; the toggle bit restarts at 0.
- Input sync: every input bit passes through 3 flops. Byte-swap is applied after sync.
- Report acceptance (tear guard): the synced counter must equal its previous-cycle value (stable for 2 cycles) AND differ from last_accepted AND mouse_active=1.
  - On accept: `report_strobe`=1 for one cycle, last_accepted updated, deltas added.
  - Latency from input change to report_strobe: 5 clk.
- Delta conversion:
  - dx = sx >>> SCALE_SHIFT.
  - dy = (INVERT_Y ? -sy : sy) >>> SCALE_SHIFT; -(-32768) saturates to +32767 before the shift.
- Accumulate: acc_x/acc_y are signed ACC_W.
  - Sum is computed at ACC_W+1 bits and saturated to [-2^(ACC_W-1), 2^(ACC_W-1)-1].
  - Saturation sets sticky ovf_x/ovf_y.
- State machine:
  - IDLE: when pending (acc_x!=0, acc_y!=0, or buttons != last_sent_buttons) -> EMIT.
  - EMIT: one cycle.
    - chunk_x = clamp(acc_x, -256, 255); chunk_y likewise.
    - ps2_mouse[7:0] = {ovf_y, ovf_x, chunk_y[8], chunk_x[8], 1'b1, M, R, L}.
    - [15:8] = chunk_x[7:0]; [23:16] = chunk_y[7:0]; [24] inverts.
    - acc -= chunk; ovf flags cleared; last_sent_buttons updated. Go to GAP.
  - GAP: count GAP_CYCLES-1 cycles, then -> IDLE. Accepts still accumulate during GAP.
- Simultaneous accept and EMIT in the same cycle: acc_next = sat(acc - chunk + delta). No report is lost.
- Button source: the synced button value at the EMIT cycle is the value sent.
- mouse_active falls:
  - Accumulators and ovf are cleared.
  - Buttons are forced to 0.
  - If last_sent_buttons != 0, one release packet {X=0, Y=0, buttons=0} is emitted after the gap.
- Counter wrap 0xFFFF->0x0000 is a normal differing value and is accepted.
- Identical counter with changed deltas: no accept.
- Packet period is >= GAP_CYCLES+1 clk between toggles. Toggle never changes twice within that window.

Test Plan:
- Reset with inputs nonzero -> all outputs 0, no toggle for 10 cycles after release; type=5, counter 0x0001, dx=+10, dy=+5 (USB) -> report_strobe at +5 clk, packet X=0x0A, Y=0xFB (INVERT_Y), status=0x28, toggle=1.
- Single report dx=+600, GAP_CYCLES=16 -> three packets X=255, 255, 90, status bit4=0, spaced >=17 cycles; acc_x ends 0.
- Two reports dx=+3 and dx=-3 within one gap -> accumulator nets 0; with buttons unchanged, no second packet.
- Counter held stable but byte-swapped halves changing on alternate cycles (tear) -> no accept until stable 2 cycles; counter 0xFFFF->0x0000 -> accepted.
- ACC_W=10, dx=+32767 ×2 -> acc_x=511, ovf_x=1 in first packet (status bit6), cleared in the next packet.
- Left button held, then type changes 5->0 -> release packet status=0x08 once; reset_n asserted mid-GAP -> toggle returns to 0 immediately.

Source files
------------

// File: rtl/usb_mouse_ps2_if.sv
// APF controller-4 mouse bridge bundle.
// Raw cont4 words in, synced state and PS/2 packet bus out.
interface usb_mouse_ps2_if;
  logic [31:0] cont4_key;
  logic [31:0] cont4_joy;
  logic [15:0] cont4_trig;
  logic        mouse_active;
  logic [2:0]  mouse_buttons;
  logic        report_strobe;
  logic [24:0] ps2_mouse;

  modport master (
    output cont4_key,
    output cont4_joy,
    output cont4_trig,
    input  mouse_active,
    input  mouse_buttons,
    input  report_strobe,
    input  ps2_mouse
  );

  modport slave (
    input  cont4_key,
    input  cont4_joy,
    input  cont4_trig,
    output mouse_active,
    output mouse_buttons,
    output report_strobe,
    output ps2_mouse
  );
endinterface

// File: rtl/usb_mouse_ps2.sv
// USB mouse reports (cont4 type 5) to rate-limited PS/2 packets.
// Ports: clk, reset_n (async low), bus (cont4 in; active/buttons/strobe/ps2 out).
module usb_mouse_ps2 #(
  parameter int ACC_W       = 16,
  parameter int GAP_CYCLES  = 1024,
  parameter int SCALE_SHIFT = 0,
  parameter bit INVERT_Y    = 1'b1
) (
  input  logic           clk,
  input  logic           reset_n,
  usb_mouse_ps2_if.slave bus
);
  // Working width: holds acc +/- a full 16-bit delta without wrap.
  localparam int SW = ((ACC_W > 16) ? ACC_W : 16) + 2;
  localparam int GW = $clog2(GAP_CYCLES + 1);

  localparam logic signed [SW-1:0] ONE   = SW'(1);
  localparam logic signed [SW-1:0] A_MAX =
    (ONE <<< (ACC_W - 1)) - ONE;
  localparam logic signed [SW-1:0] A_MIN =
    -(ONE <<< (ACC_W - 1));
  localparam logic signed [SW-1:0] C_MAX = SW'(255);
  localparam logic signed [SW-1:0] C_MIN = SW'(-256);

  typedef enum logic [1:0] {
    IDLE,
    EMIT,
    GAP
  } state_t;

  function automatic logic signed [SW-1:0] clip(
    input logic signed [SW-1:0] v,
    input logic signed [SW-1:0] lo,
    input logic signed [SW-1:0] hi
  );
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Async assert, synchronous release.
  logic [1:0] rst_sync;
  logic       rst_n;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) rst_sync <= '0;
    else          rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_n = rst_sync[1];

  logic [79:0] s1, s2, s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
      s3 <= '0;
    end else begin
      s1 <= {bus.cont4_trig, bus.cont4_joy, bus.cont4_key};
      s2 <= s1;
      s3 <= s2;
    end
  end

  logic [31:0] key_s, joy_s;
  logic [15:0] trig_s;
  assign {trig_s, joy_s, key_s} = s3;

  logic              type_ok;
  logic [15:0]       cnt;
  logic signed [15:0] sx, sy, ny, sy_eff, dx16, dy16;
  logic              unused_bits;

  assign type_ok = (key_s[31:28] == 4'h5);
  assign cnt     = {key_s[7:0], key_s[15:8]};
  assign sx      = {joy_s[7:0], joy_s[15:8]};
  assign sy      = {trig_s[7:0], trig_s[15:8]};
  // -(-32768) does not fit; pin it to +32767.
  assign ny      = (sy == 16'sh8000) ? 16'sh7fff : -sy;
  assign sy_eff  = INVERT_Y ? ny : sy;
  assign dx16    = sx >>> SCALE_SHIFT;
  assign dy16    = sy_eff >>> SCALE_SHIFT;
  assign unused_bits = ^{key_s[27:16], joy_s[31:19]};

  logic              active_q, strobe_q;
  logic [2:0]        btn_q, last_btn;
  logic [15:0]       cnt_prev, last_acc;
  logic signed [ACC_W-1:0] acc_x, acc_y;
  logic              ovf_x, ovf_y;
  logic [24:0]       ps2_q;
  state_t            state_q, state_d;
  logic [GW-1:0]     gap_q, gap_d;
  logic              emit, pending, accept;

  // Counter must be stable for two samples to reject torn reads.
  assign accept = active_q
               && (cnt == cnt_prev)
               && (cnt != last_acc);

  assign pending = (acc_x != '0)
                || (acc_y != '0)
                || (btn_q != last_btn);

  logic signed [SW-1:0] ax, ay, cx, cy;
  logic signed [SW-1:0] dxe, dye, sum_x, sum_y;
  logic signed [SW-1:0] nx, nyv;
  logic                 sat_x, sat_y;
  logic [8:0]           chunk_x, chunk_y;

  always_comb begin
    ax  = {{(SW-ACC_W){acc_x[ACC_W-1]}}, acc_x};
    ay  = {{(SW-ACC_W){acc_y[ACC_W-1]}}, acc_y};
    dxe = {{(SW-16){dx16[15]}}, dx16};
    dye = {{(SW-16){dy16[15]}}, dy16};
    cx  = clip(ax, C_MIN, C_MAX);
    cy  = clip(ay, C_MIN, C_MAX);
    chunk_x = cx[8:0];
    chunk_y = cy[8:0];
    // Drain and a new report may land in the same cycle.
    sum_x = ax;
    sum_y = ay;
    if (emit) begin
      sum_x = sum_x - cx;
      sum_y = sum_y - cy;
    end
    if (accept) begin
      sum_x = sum_x + dxe;
      sum_y = sum_y + dye;
    end
    nx    = clip(sum_x, A_MIN, A_MAX);
    nyv   = clip(sum_y, A_MIN, A_MAX);
    sat_x = (nx != sum_x);
    sat_y = (nyv != sum_y);
  end

  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    emit    = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (pending) state_d = EMIT;
      end
      EMIT: begin
        emit    = 1'b1;
        gap_d   = '0;
        state_d = (GAP_CYCLES > 1) ? GAP : IDLE;
      end
      GAP: begin
        if (gap_q == GW'(GAP_CYCLES - 2)) state_d = IDLE;
        else gap_d = gap_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      btn_q    <= '0;
      cnt_prev <= '0;
      last_acc <= '0;
      strobe_q <= 1'b0;
      acc_x    <= '0;
      acc_y    <= '0;
      ovf_x    <= 1'b0;
      ovf_y    <= 1'b0;
      last_btn <= '0;
      ps2_q    <= '0;
      state_q  <= IDLE;
      gap_q    <= '0;
    end else begin
      active_q <= type_ok;
      btn_q    <= type_ok ? joy_s[18:16] : 3'b000;
      cnt_prev <= cnt;
      strobe_q <= accept;
      if (accept) last_acc <= cnt;
      // Leaving mouse mode drops any motion not yet sent.
      if (!active_q) begin
        acc_x <= '0;
        acc_y <= '0;
        ovf_x <= 1'b0;
        ovf_y <= 1'b0;
      end else begin
        acc_x <= nx[ACC_W-1:0];
        acc_y <= nyv[ACC_W-1:0];
        ovf_x <= (ovf_x & ~emit) | sat_x;
        ovf_y <= (ovf_y & ~emit) | sat_y;
      end
      if (emit) begin
        ps2_q <= {~ps2_q[24], chunk_y[7:0], chunk_x[7:0],
                  ovf_y, ovf_x, chunk_y[8], chunk_x[8],
                  1'b1, btn_q};
        last_btn <= btn_q;
      end
      state_q <= state_d;
      gap_q   <= gap_d;
    end
  end

  assign bus.mouse_active  = active_q;
  assign bus.mouse_buttons = btn_q;
  assign bus.report_strobe = strobe_q;
  assign bus.ps2_mouse     = ps2_q;
endmodule

// File: tb/tb_usb_mouse_ps2.sv
// Bench for usb_mouse_ps2: two instances (ACC_W 16 and 10), shared stimulus.
// Packets compared against an integer accumulator model.
module tb_usb_mouse_ps2;
  localparam int GAP = 16;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  logic [31:0] key = '0;
  logic [31:0] joy = '0;
  logic [15:0] trig = '0;

  usb_mouse_ps2_if ifa ();
  usb_mouse_ps2_if ifb ();

  assign ifa.cont4_key  = key;
  assign ifa.cont4_joy  = joy;
  assign ifa.cont4_trig = trig;
  assign ifb.cont4_key  = key;
  assign ifb.cont4_joy  = joy;
  assign ifb.cont4_trig = trig;

  usb_mouse_ps2 #(
    .ACC_W(16), .GAP_CYCLES(GAP),
    .SCALE_SHIFT(0), .INVERT_Y(1'b1)
  ) dut_a (
    .clk(clk), .reset_n(reset_n), .bus(ifa)
  );

  usb_mouse_ps2 #(
    .ACC_W(10), .GAP_CYCLES(GAP),
    .SCALE_SHIFT(0), .INVERT_Y(1'b1)
  ) dut_b (
    .clk(clk), .reset_n(reset_n), .bus(ifb)
  );

  logic sel = 1'b0;
  logic [24:0] ps2;
  logic strobe, active;
  logic [2:0] btns;
  assign ps2    = sel ? ifb.ps2_mouse : ifa.ps2_mouse;
  assign strobe = sel ? ifb.report_strobe : ifa.report_strobe;
  assign active = sel ? ifb.mouse_active : ifa.mouse_active;
  assign btns   = sel ? ifb.mouse_buttons : ifa.mouse_buttons;

  int errors = 0;
  int checks = 0;

  // Reference model: plain integers.
  int m_w = 16;
  int m_ax, m_ay;
  bit m_ox, m_oy, m_tog;
  logic [2:0] m_btn, m_last;
  logic seen_tog = 1'b0;
  logic [15:0] cnt_r = 16'h0;

  function automatic int m_sat(input int v, output bit o);
    int hi, lo;
    hi = (1 <<< (m_w - 1)) - 1;
    lo = -hi - 1;
    o = (v > hi) || (v < lo);
    return (v > hi) ? hi : ((v < lo) ? lo : v);
  endfunction

  function automatic void m_add(input int dx, input int dy);
    int y;
    bit o;
    y = (dy == -32768) ? 32767 : -dy;
    m_ax = m_sat(m_ax + dx, o);
    m_ox = m_ox | o;
    m_ay = m_sat(m_ay + y, o);
    m_oy = m_oy | o;
  endfunction

  function automatic int clamp(input int v);
    return (v > 255) ? 255 : ((v < -256) ? -256 : v);
  endfunction

  function automatic logic [24:0] m_emit();
    int cx, cy;
    logic [8:0] bx, by;
    logic [24:0] r;
    cx = clamp(m_ax);
    cy = clamp(m_ay);
    bx = 9'(cx);
    by = 9'(cy);
    m_tog = ~m_tog;
    r = {m_tog, by[7:0], bx[7:0], m_oy, m_ox,
         by[8], bx[8], 1'b1, m_btn};
    m_ax -= cx;
    m_ay -= cy;
    m_ox = 0;
    m_oy = 0;
    m_last = m_btn;
    return r;
  endfunction

  function automatic bit m_pending();
    return (m_ax != 0) || (m_ay != 0) || (m_btn != m_last);
  endfunction

  task automatic drive(input logic [3:0] ty, input logic [15:0] c,
                       input logic [15:0] dx, input logic [15:0] dy,
                       input logic [2:0] b);
    key  = {ty, 12'h0, c[7:0], c[15:8]};
    joy  = {8'h0, 5'h0, b, dx[7:0], dx[15:8]};
    trig = {dy[7:0], dy[15:8]};
  endtask

  task automatic send(input int dx, input int dy, input logic [2:0] b);
    cnt_r = cnt_r + 16'd1;
    drive(4'h5, cnt_r, 16'(dx), 16'(dy), b);
    m_btn = b;
    m_add(dx, dy);
  endtask

  task automatic wait_tog(input int limit, output bit ok, output int cyc);
    ok = 1'b0;
    cyc = 0;
    while (!ok && cyc < limit) begin
      @(negedge clk);
      cyc++;
      if (ps2[24] !== seen_tog) ok = 1'b1;
    end
    if (ok) seen_tog = ps2[24];
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    drive(4'h0, 16'h0, 16'h0, 16'h0, 3'b0);
    m_ax = 0; m_ay = 0; m_ox = 0; m_oy = 0;
    m_tog = 0; m_btn = 0; m_last = 0;
    seen_tog = 1'b0;
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    bit quiet;
    sel = 1'b0;
    reset_n = 1'b0;
    drive(4'h3, 16'h1234, 16'h0055, 16'h0077, 3'b111);
    repeat (4) @(negedge clk);
    checks++;
    if ({ifa.ps2_mouse, ifa.mouse_active, ifa.mouse_buttons,
         ifa.report_strobe, ifb.ps2_mouse, ifb.mouse_active,
         ifb.mouse_buttons, ifb.report_strobe} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: ps2a=%h ps2b=%h want 0",
               ifa.ps2_mouse, ifb.ps2_mouse);
    end
    m_ax = 0; m_ay = 0; m_ox = 0; m_oy = 0;
    m_tog = 0; m_btn = 0; m_last = 0;
    reset_n = 1'b1;
    quiet = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (ps2[24] !== 1'b0 || strobe !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL reset_quiet: toggle=%b strobe=%b want 0",
               ps2[24], strobe);
    end
  endtask

  task automatic test_first_packet();
    bit early, ok;
    int cyc;
    logic [24:0] exp;
    cnt_r = 16'h0;
    send(10, 5, 3'b000);
    early = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (strobe) early = 1'b1;
    end
    @(negedge clk);
    checks++;
    if (early || strobe !== 1'b1) begin
      errors++;
      $display("FAIL strobe_latency: early=%b strobe=%b want 0/1",
               early, strobe);
    end
    wait_tog(100, ok, cyc);
    exp = m_emit();
    checks++;
    if (!ok || ps2 !== 25'h1FB0A28) begin
      errors++;
      $display("FAIL first_packet: ps2=%h want %h", ps2, 25'h1FB0A28);
    end
    checks++;
    if (ps2 !== exp) begin
      errors++;
      $display("FAIL first_model: ps2=%h want %h", ps2, exp);
    end
    repeat (GAP + 4) @(negedge clk);
  endtask

  task automatic test_drain();
    bit ok;
    int cyc;
    logic [24:0] exp;
    logic [7:0] xs [3];
    xs[0] = 8'd255; xs[1] = 8'd255; xs[2] = 8'd90;
    send(600, 0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      wait_tog(100, ok, cyc);
      exp = m_emit();
      checks++;
      if (!ok || ps2 !== exp || ps2[15:8] !== xs[i] || ps2[4]) begin
        errors++;
        $display("FAIL drain[%0d]: ps2=%h want %h x=%0d",
                 i, ps2, exp, xs[i]);
      end
      if (i > 0) begin
        checks++;
        if (cyc < GAP + 1) begin
          errors++;
          $display("FAIL drain_gap[%0d]: cycles=%0d want >=%0d",
                   i, cyc, GAP + 1);
        end
      end
    end
    wait_tog(3 * GAP, ok, cyc);
    checks++;
    if (ok) begin
      errors++;
      $display("FAIL drain_done: extra packet ps2=%h", ps2);
    end
  endtask

  task automatic test_cancel();
    bit ok;
    int cyc, n;
    logic [24:0] exp;
    send(1, 0, 3'b000);
    wait_tog(100, ok, cyc);
    exp = m_emit();
    checks++;
    if (!ok || ps2 !== exp) begin
      errors++;
      $display("FAIL cancel_prime: ps2=%h want %h", ps2, exp);
    end
    send(3, 0, 3'b000);
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (strobe) n++;
      if (i == 2) send(-3, 0, 3'b000);
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL cancel_strobes: got %0d want 2", n);
    end
    checks++;
    if (ps2[24] !== seen_tog) begin
      errors++;
      $display("FAIL cancel_nopkt: ps2=%h toggled", ps2);
    end
  endtask

  task automatic test_tear();
    int n;
    bit ok;
    int cyc;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      drive(4'h5, i[0] ? 16'h2010 : 16'h1020, 16'h0, 16'h0, 3'b0);
      @(negedge clk);
      if (strobe) n++;
    end
    checks++;
    if (n != 0) begin
      errors++;
      $display("FAIL tear_reject: strobes=%0d want 0", n);
    end
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (strobe) n++;
    end
    checks++;
    if (n != 1) begin
      errors++;
      $display("FAIL tear_settle: strobes=%0d want 1", n);
    end
    n = 0;
    drive(4'h5, 16'hFFFF, 16'h0, 16'h0, 3'b0);
    repeat (8) begin
      @(negedge clk);
      if (strobe) n++;
    end
    drive(4'h5, 16'h0000, 16'h0, 16'h0, 3'b0);
    repeat (8) begin
      @(negedge clk);
      if (strobe) n++;
    end
    checks++;
    if (n != 2) begin
      errors++;
      $display("FAIL tear_wrap: strobes=%0d want 2", n);
    end
    n = 0;
    drive(4'h5, 16'h0000, 16'h0032, 16'h0011, 3'b0);
    repeat (10) begin
      @(negedge clk);
      if (strobe) n++;
    end
    wait_tog(2 * GAP, ok, cyc);
    checks++;
    if (n != 0 || ok) begin
      errors++;
      $display("FAIL same_counter: strobes=%0d pkt=%b want 0/0",
               n, ok);
    end
  endtask

  task automatic test_saturate();
    bit ok;
    int cyc;
    logic [24:0] exp;
    do_reset();
    sel = 1'b1;
    m_w = 10;
    send(1, 0, 3'b000);
    wait_tog(100, ok, cyc);
    exp = m_emit();
    checks++;
    if (!ok || ps2 !== exp) begin
      errors++;
      $display("FAIL sat_prime: ps2=%h want %h", ps2, exp);
    end
    send(32767, 0, 3'b000);
    repeat (3) @(negedge clk);
    send(32767, 0, 3'b000);
    for (int i = 0; i < 3; i++) begin
      wait_tog(100, ok, cyc);
      exp = m_emit();
      checks++;
      if (!ok || ps2 !== exp || ps2[6] !== (i == 0)) begin
        errors++;
        $display("FAIL sat[%0d]: ps2=%h want %h", i, ps2, exp);
      end
    end
    sel = 1'b0;
    m_w = 16;
  endtask

  task automatic test_release();
    bit ok;
    int cyc;
    logic [24:0] exp;
    do_reset();
    sel = 1'b0;
    send(0, 0, 3'b001);
    wait_tog(100, ok, cyc);
    exp = m_emit();
    checks++;
    if (!ok || ps2 !== exp || ps2[7:0] !== 8'h09) begin
      errors++;
      $display("FAIL press: ps2=%h want %h", ps2, exp);
    end
    drive(4'h0, cnt_r, 16'h0, 16'h0, 3'b001);
    m_btn = 0; m_ax = 0; m_ay = 0; m_ox = 0; m_oy = 0;
    wait_tog(100, ok, cyc);
    exp = m_emit();
    checks++;
    if (!ok || ps2 !== exp || ps2[23:0] !== 24'h000008) begin
      errors++;
      $display("FAIL release: ps2=%h want %h", ps2, exp);
    end
    checks++;
    if (active !== 1'b0 || btns !== 3'b000) begin
      errors++;
      $display("FAIL inactive: active=%b btns=%b want 0/000",
               active, btns);
    end
    wait_tog(60, ok, cyc);
    checks++;
    if (ok) begin
      errors++;
      $display("FAIL release_once: extra ps2=%h", ps2);
    end
    send(0, 0, 3'b010);
    wait_tog(100, ok, cyc);
    exp = m_emit();
    repeat (3) @(negedge clk);
    reset_n = 1'b0;
    #1;
    checks++;
    if (!ok || ifa.ps2_mouse !== 25'h0) begin
      errors++;
      $display("FAIL midgap_reset: ps2=%h pkt=%b want 0", ifa.ps2_mouse, ok);
    end
    do_reset();
  endtask

  task automatic test_random();
    bit ok;
    int cyc, dx, dy, guard;
    logic [24:0] exp;
    do_reset();
    sel = 1'b0;
    send(0, -32768, 3'b000);
    guard = 0;
    while (m_pending() && guard < 200) begin
      wait_tog(100, ok, cyc);
      exp = m_emit();
      guard++;
      checks++;
      if (!ok || ps2 !== exp) begin
        errors++;
        $display("FAIL neg_min[%0d]: ps2=%h want %h", guard, ps2, exp);
        guard = 200;
      end
    end
    repeat (GAP + 4) @(negedge clk);
    for (int it = 0; it < 12; it++) begin
      dx = int'($urandom_range(1400)) - 700;
      dy = int'($urandom_range(1400)) - 700;
      send(dx, dy, 3'($urandom_range(7)));
      guard = 0;
      while (m_pending() && guard < 20) begin
        wait_tog(100, ok, cyc);
        exp = m_emit();
        guard++;
        checks++;
        if (!ok || ps2 !== exp) begin
          errors++;
          $display("FAIL random[%0d]: ps2=%h want %h", it, ps2, exp);
          guard = 20;
        end
      end
      repeat (GAP + 4) @(negedge clk);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_packet();
    test_drain();
    test_cancel();
    test_tear();
    test_saturate();
    test_release();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
